// File: rtl/rob_commit.sv
// Reorder buffer: allocates entries in program order, captures CDB results,
// answers two operand lookups and retires one entry per cycle to the regfile.
//
// Allocation handshake: an entry is taken on a clock edge only when
// alloc_valid and alloc_ready are both high and flush is low. alloc_tag is
// meaningful in that same cycle, and a request made while alloc_ready is low
// leaves all state untouched.
module rob_commit #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_val,
   input  logic [TAG_W-1:0] lk1_tag,
   input  logic [TAG_W-1:0] lk2_tag,
   output logic             lk1_ready,
   output logic             lk2_ready,
   output logic [31:0]      lk1_val,
   output logic [31:0]      lk2_val,
   output logic             load,
   output logic [4:0]       rd,
   output logic [31:0]      val,
   output logic [TAG_W-1:0] tag,
   output logic             empty,
   output logic [TAG_W:0]   count
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] done_q;
   logic [4:0]       rd_mem  [DEPTH];
   logic [31:0]      val_mem [DEPTH];
   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W:0]   count_q;

   logic alloc_fire;
   logic cdb_fire;
   logic commit_fire;

   // Event qualifiers; flush squashes every other action in its cycle.
   always_comb begin
      alloc_ready = (count_q < FULL_CNT);
      alloc_fire  = alloc_valid && alloc_ready && !flush;
      cdb_fire    = cdb_valid && busy_q[cdb_tag] && !flush;
      commit_fire = busy_q[head_q] && done_q[head_q] && !flush;
   end

   assign alloc_tag = tail_q;
   assign count     = count_q;
   assign empty     = (count_q == '0);

   // Per-entry storage: capture results, retire the head, claim the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         done_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem[i]  <= '0;
            val_mem[i] <= '0;
         end
      end else if (flush) begin
         busy_q <= '0;
         done_q <= '0;
      end else begin
         if (cdb_fire) begin
            val_mem[cdb_tag] <= cdb_val;
            done_q[cdb_tag]  <= 1'b1;
         end
         if (commit_fire) begin
            busy_q[head_q] <= 1'b0;
            done_q[head_q] <= 1'b0;
         end
         if (alloc_fire) begin
            busy_q[tail_q] <= 1'b1;
            done_q[tail_q] <= 1'b0;
            rd_mem[tail_q] <= alloc_rd;
         end
      end
   end

   // Head/tail pointers wrap naturally at DEPTH; count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc_fire)
            tail_q <= tail_q + TAG_W'(1);
         if (commit_fire)
            head_q <= head_q + TAG_W'(1);
         case ({alloc_fire, commit_fire})
            2'b10:   count_q <= count_q + (TAG_W+1)'(1);
            2'b01:   count_q <= count_q - (TAG_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Regfile write port; rd/val/tag hold between commits, x0 retires silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load <= 1'b0;
         rd   <= '0;
         val  <= '0;
         tag  <= '0;
      end else if (commit_fire) begin
         load <= (rd_mem[head_q] != 5'd0);
         rd   <= rd_mem[head_q];
         val  <= val_mem[head_q];
         tag  <= head_q;
      end else begin
         load <= 1'b0;
      end
   end

   // Lookup port 1: a same-cycle CDB broadcast bypasses the stored value.
   always_comb begin
      lk1_ready = 1'b0;
      lk1_val   = '0;
      if (cdb_valid && (cdb_tag == lk1_tag)) begin
         lk1_ready = 1'b1;
         lk1_val   = cdb_val;
      end else if (busy_q[lk1_tag] && done_q[lk1_tag]) begin
         lk1_ready = 1'b1;
         lk1_val   = val_mem[lk1_tag];
      end
   end

   // Lookup port 2: same rules as port 1.
   always_comb begin
      lk2_ready = 1'b0;
      lk2_val   = '0;
      if (cdb_valid && (cdb_tag == lk2_tag)) begin
         lk2_ready = 1'b1;
         lk2_val   = cdb_val;
      end else if (busy_q[lk2_tag] && done_q[lk2_tag]) begin
         lk2_ready = 1'b1;
         lk2_val   = val_mem[lk2_tag];
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected commits go into a queue, a monitor
// pops and compares on every load pulse, and direct checks cover the rest.
module tb_rob_commit;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             alloc_valid;
   logic [4:0]       alloc_rd;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_val;
   logic [TAG_W-1:0] lk1_tag;
   logic [TAG_W-1:0] lk2_tag;
   logic             lk1_ready;
   logic             lk2_ready;
   logic [31:0]      lk1_val;
   logic [31:0]      lk2_val;
   logic             load;
   logic [4:0]       rd;
   logic [31:0]      val;
   logic [TAG_W-1:0] tag;
   logic             empty;
   logic [TAG_W:0]   count;

   // Expected commit record: {rd, val, tag}
   logic [39:0] exp_q[$];
   int checks;
   int errors;

   rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .lk1_tag(lk1_tag), .lk2_tag(lk2_tag),
      .lk1_ready(lk1_ready), .lk2_ready(lk2_ready),
      .lk1_val(lk1_val), .lk2_val(lk2_val),
      .load(load), .rd(rd), .val(val), .tag(tag),
      .empty(empty), .count(count)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_alloc(input logic [4:0] r, input logic [TAG_W-1:0] exp_tag);
      alloc_valid = 1'b1;
      alloc_rd    = r;
      #1;
      check("alloc_tag", alloc_tag, exp_tag);
      check("alloc_ready", alloc_ready, 1);
      cyc();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_val   = v;
      cyc();
      cdb_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [4:0] r, input logic [31:0] v, input logic [TAG_W-1:0] t);
      exp_q.push_back({r, v, t});
   endtask

   // Monitor: every load pulse must match the oldest expected commit.
   always @(negedge clk) begin
      if (!rst && load) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got rd=%0d val=%0h tag=%0d expected no load", rd, val, tag);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("commit_record", {rd, val, tag}, e);
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      alloc_valid = 1'b0;
      alloc_rd    = '0;
      cdb_valid   = 1'b0;
      cdb_tag     = '0;
      cdb_val     = '0;
      lk1_tag     = '0;
      lk2_tag     = '0;
      idle(2);
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_load", load, 0);
      check("rst_rd", rd, 0);
      check("rst_val", val, 0);
      check("rst_tag", tag, 0);
      check("rst_empty", empty, 1);
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_alloc_tag", alloc_tag, 0);
      check("rst_count", count, 0);

      // Asynchronous reset mid-operation
      do_alloc(5'd1, 3'd0);
      do_alloc(5'd2, 3'd1);
      do_alloc(5'd3, 3'd2);
      check("pre_rst_count", count, 3);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_count", count, 0);
      check("async_rst_empty", empty, 1);
      check("async_rst_tail", alloc_tag, 0);
      check("async_rst_load", load, 0);
      cyc();
      rst = 1'b0;

      // In-order retire with out-of-order completion
      do_alloc(5'd5, 3'd0);
      do_alloc(5'd6, 3'd1);
      do_alloc(5'd7, 3'd2);
      do_cdb(3'd2, 32'h30);
      idle(2);
      check("no_early_commit_count", count, 3);
      push_exp(5'd5, 32'h10, 3'd0);
      push_exp(5'd6, 32'h20, 3'd1);
      push_exp(5'd7, 32'h30, 3'd2);
      do_cdb(3'd0, 32'h10);
      do_cdb(3'd1, 32'h20);
      idle(4);
      check("inorder_count", count, 0);
      check("inorder_empty", empty, 1);
      check("hold_rd", rd, 7);
      check("hold_val", val, 32'h30);
      check("hold_tag", tag, 2);

      // Lookup bypass on tag 3, then stored value
      do_alloc(5'd9, 3'd3);
      push_exp(5'd9, 32'hDEADBEEF, 3'd3);
      lk1_tag   = 3'd3;
      lk2_tag   = 3'd4;
      cdb_valid = 1'b1;
      cdb_tag   = 3'd3;
      cdb_val   = 32'hDEADBEEF;
      #1;
      check("bypass_lk1_ready", lk1_ready, 1);
      check("bypass_lk1_val", lk1_val, 32'hDEADBEEF);
      check("idle_lk2_ready", lk2_ready, 0);
      check("idle_lk2_val", lk2_val, 0);
      cyc();
      cdb_valid = 1'b0;
      #1;
      check("stored_lk1_ready", lk1_ready, 1);
      check("stored_lk1_val", lk1_val, 32'hDEADBEEF);
      cyc();
      check("retired_lk1_ready", lk1_ready, 0);
      check("retired_lk1_val", lk1_val, 0);
      idle(1);

      // x0 destination retiring alongside an allocation
      do_alloc(5'd0, 3'd4);
      do_cdb(3'd4, 32'h55);
      check("x0_pre_count", count, 1);
      do_alloc(5'd3, 3'd5);
      check("x0_load", load, 0);
      check("x0_rd", rd, 0);
      check("x0_val", val, 32'h55);
      check("x0_tag", tag, 4);
      check("simul_count", count, 1);
      push_exp(5'd3, 32'h66, 3'd5);
      do_cdb(3'd5, 32'h66);
      idle(3);
      check("x0_done_count", count, 0);

      // Flush with the head done and an allocation request in the same cycle
      do_alloc(5'd1, 3'd6);
      do_alloc(5'd2, 3'd7);
      do_alloc(5'd3, 3'd0);
      do_alloc(5'd4, 3'd1);
      do_cdb(3'd6, 32'h77);
      flush       = 1'b1;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      cyc();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      #1;
      check("flush_load", load, 0);
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_alloc_tag", alloc_tag, 0);
      idle(2);

      // Fill to DEPTH, reject a 9th request, then free tag 0 and wrap
      for (int i = 0; i < DEPTH; i++) do_alloc(5'(i + 1), TAG_W'(i));
      check("full_count", count, 8);
      check("full_empty", empty, 0);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd20;
      #1;
      check("full_alloc_ready", alloc_ready, 0);
      check("full_alloc_tag", alloc_tag, 0);
      cyc();
      alloc_valid = 1'b0;
      check("full_ignored_count", count, 8);
      push_exp(5'd1, 32'hAA, 3'd0);
      do_cdb(3'd0, 32'hAA);
      check("full_still_not_ready", alloc_ready, 0);
      cyc();
      check("after_commit_count", count, 7);
      check("after_commit_ready", alloc_ready, 1);
      do_alloc(5'd21, 3'd0);
      check("wrap_count", count, 8);
      idle(3);

      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
